// File: rtl/osc_timer_arbiter.sv
// osc_timer_arbiter: one down-counter timer shared round-robin among NREQ requesters.
// A requester asks for a delay of D ticks. The block grants it the timer, counts D,
// and then pulses done to that requester.
// Optional build macro OSC_TIMER_PRESCALE_EN: a PRESCALE-cycle prescaler divides
// the count rate, so one tick equals PRESCALE oscillator cycles.
module osc_timer_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned PRESCALE = 105
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] cnt_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      cnt_out
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] pick;
  logic          found;
  logic [OW:0]   sum;
  logic [OW-1:0] owner_inc;
  logic          tick;
  logic [CW-1:0] delay [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign delay[i] = cnt_in[i*CW +: CW];
  end

`ifdef OSC_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] psc_q;

  // Prescaler: held at zero outside RUN so every RUN starts on a fresh period.
  always_ff @(posedge clk) begin
    if (rst || state_q != StRun) begin
      psc_q <= '0;
    end else if (psc_q == PW'(PRESCALE - 1)) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_q + PW'(1);
    end
  end

  assign tick = (psc_q == PW'(PRESCALE - 1));
`else
  assign tick = 1'b1;
`endif

  // Round-robin pick: first requesting index at or above rr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (OW+1)'(k);
      if (sum >= (OW+1)'(NREQ)) sum = sum - (OW+1)'(NREQ);
      if (!found && req[sum[OW-1:0]]) begin
        found = 1'b1;
        pick  = sum[OW-1:0];
      end
    end
  end

  assign owner_inc = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  // Next-state logic: grant, count down, finish or abort.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StRun;
          owner_d = pick;
          cnt_d   = delay[pick];
        end
      end
      StRun: begin
        // The owner dropping its request takes priority over completion.
        if (!req[owner_q]) begin
          state_d = StIdle;
          rr_d    = owner_inc;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == '0) begin
            state_d = StDone;
            rr_d    = owner_inc;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = (state_q == StRun)  ? (NREQ'(1) << owner_q) : '0;
  assign done    = (state_q == StDone) ? (NREQ'(1) << owner_q) : '0;
  assign busy    = (state_q != StIdle);
  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_osc_timer_arbiter.sv
// Directed self-checking bench for osc_timer_arbiter (NREQ=4, CW=16).
// With OSC_TIMER_PRESCALE_EN defined, the DUT uses PRESCALE=4 and expected
// durations scale by that tick length.
module tb_osc_timer_arbiter;

`ifdef OSC_TIMER_PRESCALE_EN
  localparam int TK = 4;
`else
  localparam int TK = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] cnt_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [15:0] cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  osc_timer_arbiter #(
    .NREQ     (4),
    .CW       (16),
    .PRESCALE (TK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cnt_in  (cnt_in),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cnt(input int i, input logic [15:0] v);
    cnt_in[i*16 +: 16] = v;
  endtask

  // Waits for a grant, then checks owner, grant length, the done pulse and its clearing.
  // Returns with the sample taken in IDLE after the DONE cycle.
  task automatic expect_run(input string tag, input int own, input int d);
    logic [3:0] oh;
    int waited;
    int n;
    oh = 4'(1 << own);
    waited = 0;
    n = 0;
    while (gnt == 4'b0 && waited < 50) begin
      step();
      waited++;
    end
    chk({tag, " owner"}, 32'(gnt), 32'(oh));
    while (gnt == oh && n < 5000) begin
      n++;
      step();
    end
    chk({tag, " gnt_len"}, 32'(n), 32'((d + 1) * TK));
    chk({tag, " done"}, 32'(done), 32'(oh));
    chk({tag, " gnt_off"}, 32'(gnt), 32'h0);
    step();
    chk({tag, " done_clr"}, 32'(done), 32'h0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    req = 4'b1111;
    cnt_in = '0;
    for (int i = 0; i < 4; i++) set_cnt(i, 16'd2);

    // Reset held three cycles with all requests high: outputs stay quiet.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst gnt", 32'(gnt), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst cnt", 32'(cnt_out), 32'h0);
    end
    rst = 1'b0;
    step();
    chk("first gnt", 32'(gnt), 32'h1);
    chk("first busy", 32'(busy), 32'h1);
    chk("first cnt", 32'(cnt_out), 32'd2);
    // Owner 0 withdraws: immediate abort, pointer moves to 1.
    req = 4'b0000;
    step();
    chk("wd gnt", 32'(gnt), 32'h0);
    chk("wd done", 32'(done), 32'h0);
    chk("wd busy", 32'(busy), 32'h0);

    // Single delay of 5 on requester 2.
    set_cnt(2, 16'd5);
    req = 4'b0100;
    expect_run("single", 2, 5);
    chk("single idle", 32'(busy), 32'h0);
    req = 4'b0000;

    // Zero delay on requester 1.
    set_cnt(1, 16'd0);
    req = 4'b0010;
    expect_run("zero", 1, 0);
    req = 4'b0000;

    // Round-robin from a fresh pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_cnt(i, 16'd2);
    req = 4'b1111;
    expect_run("rr0", 0, 2);
    expect_run("rr1", 1, 2);
    expect_run("rr2", 2, 2);
    expect_run("rr3", 3, 2);
    expect_run("rr0b", 0, 2);
    req = 4'b0000;

    // Abort: pointer is 1, so requester 3 wins over pending requester 0.
    set_cnt(3, 16'd10);
    set_cnt(0, 16'd3);
    req = 4'b1001;
    step();
    for (int s = 0; s < 4; s++) begin
      chk("abort gnt", 32'(gnt), 32'h8);
      chk("abort cnt", 32'(cnt_out), 32'(10 - s / TK));
      if (s < 3) step();
    end
    req = 4'b0001;
    step();
    chk("abort gnt_off", 32'(gnt), 32'h0);
    chk("abort no_done", 32'(done), 32'h0);
    step();
    chk("after abort gnt", 32'(gnt), 32'h1);
    guard = 0;
    while (gnt != 4'b0 && guard < 200) begin
      step();
      guard++;
    end
    chk("after abort done", 32'(done), 32'h1);
    step();
    req = 4'b0000;

    // Reset mid-RUN with requester 1's counter at 7.
    set_cnt(1, 16'd20);
    req = 4'b0010;
    step();
    chk("mid owner", 32'(gnt), 32'h2);
    guard = 0;
    while (cnt_out != 16'd7 && guard < 200) begin
      step();
      guard++;
    end
    chk("mid cnt", 32'(cnt_out), 32'd7);
    rst = 1'b1;
    step();
    chk("mid rst gnt", 32'(gnt), 32'h0);
    chk("mid rst done", 32'(done), 32'h0);
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst cnt", 32'(cnt_out), 32'h0);
    step();
    chk("mid rst done2", 32'(done), 32'h0);
    rst = 1'b0;
    req = 4'b0000;
    step();
    chk("end idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
